// File: rtl/dcache_rob_rcv_pkg.sv
// Shared dcache definitions: receiver FSM states, queue opcodes, CDB handshake
// bundle and wait-counter sizing.
package dcache_rob_rcv_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CDB_WAIT   = 2'd1,
    ST_CMPL    = 2'd2,
    FLUSH_WAIT = 2'd3
  } rcv_state_t;

  typedef enum logic [1:0] {
    LD    = 2'd0,
    ST    = 2'd1,
    FLUSH = 2'd2
  } dq_op_t;

  // Outgoing CDB handshake bundle (request side plus broadcast strobe).
  typedef struct packed {
    logic req;
    logic prio;
    logic valid;
  } cdb_hs_t;

  localparam int unsigned CNT_W = 8;

  // Classify a queue head; a flush wins over the store bit.
  function automatic dq_op_t head_op(input logic is_st, input logic is_flush);
    if (is_flush)   return FLUSH;
    else if (is_st) return ST;
    else            return LD;
  endfunction

endpackage

// File: rtl/dcache_rob_rcv_sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Clear has priority over increment; increment holds at all-ones.
  always_ff @(posedge clk) begin
    if (!rst)                        count <= '0;
    else if (clr)                    count <= '0;
    else if (inc && (count != '1))   count <= count + 1'b1;
  end

endmodule

// File: rtl/dcache_rob_rcv.sv
// ROB-side receiver for the dcache output queue: pops one completed memory
// operation at a time and retires it over the CDB, as a store completion, or
// through the flush handshake.
module dcache_rob_rcv
  import dcache_rob_rcv_pkg::*;
#(
  parameter int unsigned DATA_SIZE    = 32,
  parameter int unsigned OOO_TAG_SIZE = 10,
  parameter int unsigned OOO_ROB_SIZE = 10,
  parameter int unsigned PRIO_THRESH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    resteer,
  input  logic                    valid_in,
  input  logic [31:0]             addr_in,
  input  logic [DATA_SIZE-1:0]    data_in,
  input  logic                    is_st_in,
  input  logic                    is_flush_in,
  input  logic [OOO_TAG_SIZE-1:0] tag_in,
  input  logic [OOO_ROB_SIZE-1:0] rob_line_in,
  output logic                    dealloc,
  output logic                    resteer_out,
  output logic                    cdb_req,
  output logic                    cdb_prio,
  input  logic                    cdb_gnt,
  output logic                    cdb_valid,
  output logic [OOO_TAG_SIZE-1:0] cdb_tag,
  output logic [DATA_SIZE-1:0]    cdb_data,
  output logic                    flush_req,
  input  logic                    flush_ack,
  output logic                    rob_cmpl_valid,
  output logic [OOO_ROB_SIZE-1:0] rob_cmpl_line,
  output logic [31:0]             rob_cmpl_addr,
  output logic                    rob_cmpl_is_st
);

  localparam logic [CNT_W-1:0] PRIO_CNT = CNT_W'(PRIO_THRESH);

  rcv_state_t state, state_nxt;

  logic [31:0]             hold_addr;
  logic [DATA_SIZE-1:0]    hold_data;
  logic                    hold_is_st;
  logic                    hold_is_flush;
  logic [OOO_TAG_SIZE-1:0] hold_tag;
  logic [OOO_ROB_SIZE-1:0] hold_line;

  logic [CNT_W-1:0] wait_cnt;
  cdb_hs_t          cdb_hs;

  assign dealloc     = (state == IDLE) & valid_in & ~resteer;
  assign resteer_out = resteer;

  assign cdb_req   = cdb_hs.req;
  assign cdb_prio  = cdb_hs.prio;
  assign cdb_valid = cdb_hs.valid;

  // CDB wait counter restarts on every pop and counts ungranted CDB_WAIT cycles.
  sat_counter #(
    .WIDTH (CNT_W)
  ) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (dealloc),
    .inc   ((state == CDB_WAIT) & ~cdb_gnt),
    .count (wait_cnt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state: resteer always returns to IDLE, dropping the held entry.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (dealloc) begin
          case (head_op(is_st_in, is_flush_in))
            FLUSH:   state_nxt = FLUSH_WAIT;
            ST:      state_nxt = ST_CMPL;
            default: state_nxt = CDB_WAIT;
          endcase
        end
      end
      CDB_WAIT:   if (resteer || cdb_gnt)   state_nxt = IDLE;
      ST_CMPL:    state_nxt = IDLE;
      FLUSH_WAIT: if (resteer || flush_ack) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Hold register captures the queue head on the popping edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_addr     <= '0;
      hold_data     <= '0;
      hold_is_st    <= 1'b0;
      hold_is_flush <= 1'b0;
      hold_tag      <= '0;
      hold_line     <= '0;
    end else if (dealloc) begin
      hold_addr     <= addr_in;
      hold_data     <= data_in;
      hold_is_st    <= is_st_in;
      hold_is_flush <= is_flush_in;
      hold_tag      <= tag_in;
      hold_line     <= rob_line_in;
    end
  end

  // Outputs: all requests/strobes/payloads are zero unless driven by the
  // current state; a resteer or reset cycle suppresses every handshake.
  always_comb begin
    cdb_hs         = '0;
    cdb_tag        = '0;
    cdb_data       = '0;
    flush_req      = 1'b0;
    rob_cmpl_valid = 1'b0;
    rob_cmpl_line  = '0;
    rob_cmpl_addr  = '0;
    rob_cmpl_is_st = 1'b0;
    if (rst && !resteer) begin
      case (state)
        CDB_WAIT: begin
          cdb_hs.req  = 1'b1;
          cdb_hs.prio = (wait_cnt >= PRIO_CNT);
          if (cdb_gnt) begin
            cdb_hs.valid   = 1'b1;
            cdb_tag        = hold_tag;
            cdb_data       = hold_data;
            rob_cmpl_valid = 1'b1;
            rob_cmpl_line  = hold_line;
            rob_cmpl_addr  = hold_addr;
          end
        end
        ST_CMPL: begin
          rob_cmpl_valid = 1'b1;
          rob_cmpl_line  = hold_line;
          rob_cmpl_addr  = hold_addr;
          rob_cmpl_is_st = hold_is_st;
        end
        FLUSH_WAIT: begin
          flush_req = hold_is_flush;
          if (flush_ack) begin
            rob_cmpl_valid = 1'b1;
            rob_cmpl_line  = hold_line;
            rob_cmpl_addr  = hold_addr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_rob_rcv.sv
// Scoreboard bench for dcache_rob_rcv: stimulus pushes per-cycle control
// expectations and completion records; a monitor pops and compares.
module tb_dcache_rob_rcv;

  logic        clk;
  logic        rst;
  logic        resteer;
  logic        valid_in;
  logic [31:0] addr_in;
  logic [31:0] data_in;
  logic        is_st_in;
  logic        is_flush_in;
  logic [9:0]  tag_in;
  logic [9:0]  rob_line_in;
  logic        dealloc;
  logic        resteer_out;
  logic        cdb_req;
  logic        cdb_prio;
  logic        cdb_gnt;
  logic        cdb_valid;
  logic [9:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        flush_req;
  logic        flush_ack;
  logic        rob_cmpl_valid;
  logic [9:0]  rob_cmpl_line;
  logic [31:0] rob_cmpl_addr;
  logic        rob_cmpl_is_st;

  typedef struct packed {
    logic        cdb_v;
    logic [9:0]  tag;
    logic [31:0] data;
    logic        cmpl_v;
    logic [9:0]  line;
    logic [31:0] addr;
    logic        is_st;
  } cmpl_t;

  typedef struct packed {
    logic       chk;
    logic [4:0] v;   // {dealloc, cdb_req, cdb_prio, flush_req, resteer_out}
  } ctl_t;

  cmpl_t exp_q[$];
  ctl_t  ctl_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  bit    done  = 1'b0;

  dcache_rob_rcv #(
    .DATA_SIZE    (32),
    .OOO_TAG_SIZE (10),
    .OOO_ROB_SIZE (10),
    .PRIO_THRESH  (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .resteer        (resteer),
    .valid_in       (valid_in),
    .addr_in        (addr_in),
    .data_in        (data_in),
    .is_st_in       (is_st_in),
    .is_flush_in    (is_flush_in),
    .tag_in         (tag_in),
    .rob_line_in    (rob_line_in),
    .dealloc        (dealloc),
    .resteer_out    (resteer_out),
    .cdb_req        (cdb_req),
    .cdb_prio       (cdb_prio),
    .cdb_gnt        (cdb_gnt),
    .cdb_valid      (cdb_valid),
    .cdb_tag        (cdb_tag),
    .cdb_data       (cdb_data),
    .flush_req      (flush_req),
    .flush_ack      (flush_ack),
    .rob_cmpl_valid (rob_cmpl_valid),
    .rob_cmpl_line  (rob_cmpl_line),
    .rob_cmpl_addr  (rob_cmpl_addr),
    .rob_cmpl_is_st (rob_cmpl_is_st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] c(input logic d, input logic r, input logic p,
                                   input logic f, input logic s);
    return {d, r, p, f, s};
  endfunction

  // One cycle: register the control expectation, then advance past the edge.
  task automatic cyc(input logic chk, input logic [4:0] v);
    ctl_q.push_back(ctl_t'{chk: chk, v: v});
    @(posedge clk);
    #1;
  endtask

  task automatic head(input logic st, input logic fl, input logic [31:0] a,
                      input logic [31:0] d, input logic [9:0] t, input logic [9:0] l);
    valid_in    = 1'b1;
    is_st_in    = st;
    is_flush_in = fl;
    addr_in     = a;
    data_in     = d;
    tag_in      = t;
    rob_line_in = l;
  endtask

  task automatic clr_head();
    valid_in    = 1'b0;
    is_st_in    = 1'b0;
    is_flush_in = 1'b0;
    addr_in     = '0;
    data_in     = '0;
    tag_in      = '0;
    rob_line_in = '0;
  endtask

  task automatic push_cmpl(input logic cdb, input logic [9:0] t, input logic [31:0] d,
                           input logic [9:0] l, input logic [31:0] a, input logic st);
    exp_q.push_back(cmpl_t'{cdb_v: cdb, tag: t, data: d, cmpl_v: 1'b1,
                            line: l, addr: a, is_st: st});
  endtask

  // Stimulus
  initial begin
    rst = 1'b0; resteer = 1'b0; cdb_gnt = 1'b0; flush_ack = 1'b0;
    clr_head();
    @(posedge clk); #1;
    repeat (3) cyc(1'b1, c(0,0,0,0,0));
    rst = 1'b1;
    cyc(1'b1, c(0,0,0,0,0));

    // Load, grant tied high (grant in IDLE is ignored)
    cdb_gnt = 1'b1;
    head(1'b0, 1'b0, 32'h0000_0040, 32'hDEAD_BEEF, 10'h005, 10'd3);
    cyc(1'b1, c(1,0,0,0,0));
    clr_head();
    push_cmpl(1'b1, 10'h005, 32'hDEAD_BEEF, 10'd3, 32'h0000_0040, 1'b0);
    cyc(1'b1, c(0,1,0,0,0));
    cdb_gnt = 1'b0;
    cyc(1'b1, c(0,0,0,0,0));

    // Store; flush_ack outside FLUSH_WAIT is ignored
    head(1'b1, 1'b0, 32'h0000_1000, 32'h0000_1234, 10'h009, 10'd7);
    cyc(1'b1, c(1,0,0,0,0));
    clr_head();
    flush_ack = 1'b1;
    push_cmpl(1'b0, 10'h000, 32'h0, 10'd7, 32'h0000_1000, 1'b1);
    cyc(1'b1, c(0,0,0,0,0));
    flush_ack = 1'b0;
    cyc(1'b1, c(0,0,0,0,0));

    // Load with grant withheld for 10 cycles: prio from the 9th wait cycle
    head(1'b0, 1'b0, 32'h0000_2000, 32'hCAFE_F00D, 10'h02A, 10'd12);
    cyc(1'b1, c(1,0,0,0,0));
    clr_head();
    for (int k = 1; k <= 10; k++) cyc(1'b1, c(0, 1, (k >= 9), 0, 0));
    cdb_gnt = 1'b1;
    push_cmpl(1'b1, 10'h02A, 32'hCAFE_F00D, 10'd12, 32'h0000_2000, 1'b0);
    cyc(1'b1, c(0,1,1,0,0));
    cdb_gnt = 1'b0;
    cyc(1'b1, c(0,0,0,0,0));

    // Store+flush head is a flush; stray grant in FLUSH_WAIT ignored
    head(1'b1, 1'b1, 32'h0000_3000, 32'h0000_0055, 10'h011, 10'd20);
    cyc(1'b1, c(1,0,0,0,0));
    clr_head();
    for (int k = 1; k <= 4; k++) begin
      cdb_gnt = (k == 2);
      cyc(1'b1, c(0,0,0,1,0));
    end
    cdb_gnt   = 1'b0;
    flush_ack = 1'b1;
    push_cmpl(1'b0, 10'h000, 32'h0, 10'd20, 32'h0000_3000, 1'b0);
    cyc(1'b1, c(0,0,0,1,0));
    flush_ack = 1'b0;
    cyc(1'b1, c(0,0,0,0,0));

    // Resteer coinciding with grant; then resteer in IDLE blocks dealloc
    head(1'b0, 1'b0, 32'h0000_6000, 32'h0000_0077, 10'h033, 10'd5);
    cyc(1'b1, c(1,0,0,0,0));
    clr_head();
    cyc(1'b1, c(0,1,0,0,0));
    cdb_gnt = 1'b1; resteer = 1'b1; valid_in = 1'b1;
    cyc(1'b1, c(0,0,0,0,1));
    cdb_gnt = 1'b0;
    cyc(1'b1, c(0,0,0,0,1));
    resteer = 1'b0;
    head(1'b1, 1'b0, 32'h0000_4000, 32'h0000_0088, 10'h044, 10'd4);
    cyc(1'b1, c(1,0,0,0,0));
    clr_head();
    push_cmpl(1'b0, 10'h000, 32'h0, 10'd4, 32'h0000_4000, 1'b1);
    cyc(1'b1, c(0,0,0,0,0));
    cyc(1'b1, c(0,0,0,0,0));

    // Reset during FLUSH_WAIT alongside ack: no completion, then normal pop
    head(1'b0, 1'b1, 32'h0000_5000, 32'h0000_0099, 10'h01E, 10'd30);
    cyc(1'b1, c(1,0,0,0,0));
    clr_head();
    cyc(1'b1, c(0,0,0,1,0));
    rst = 1'b0; flush_ack = 1'b1;
    cyc(1'b0, c(0,0,0,0,0));
    rst = 1'b1; flush_ack = 1'b0;
    cyc(1'b1, c(0,0,0,0,0));
    cdb_gnt = 1'b1;
    head(1'b0, 1'b0, 32'h0000_7000, 32'hA5A5_A5A5, 10'h03F, 10'd9);
    cyc(1'b1, c(1,0,0,0,0));
    clr_head();
    push_cmpl(1'b1, 10'h03F, 32'hA5A5_A5A5, 10'd9, 32'h0000_7000, 1'b0);
    cyc(1'b1, c(0,1,0,0,0));
    cdb_gnt = 1'b0;
    cyc(1'b1, c(0,0,0,0,0));
    cyc(1'b1, c(0,0,0,0,0));
    done = 1'b1;
  end

  // Monitor / scoreboard, sampling on the falling edge
  initial begin
    cmpl_t      act;
    cmpl_t      e;
    ctl_t       ce;
    logic [4:0] actc;
    int         cycles;
    cycles = 0;
    while (!done && cycles < 3000) begin
      @(negedge clk);
      cycles++;
      if (!done) begin
        if (ctl_q.size() > 0) begin
          ce = ctl_q.pop_front();
          if (ce.chk) begin
            n_vec++;
            actc = {dealloc, cdb_req, cdb_prio, flush_req, resteer_out};
            if (actc !== ce.v) begin
              n_err++;
              $display("FAIL ctl t=%0t {dealloc,req,prio,flush_req,resteer_out} got %b want %b",
                       $time, actc, ce.v);
            end
          end
        end
        act = {cdb_valid, cdb_tag, cdb_data, rob_cmpl_valid, rob_cmpl_line,
               rob_cmpl_addr, rob_cmpl_is_st};
        n_vec++;
        if (cdb_valid || rob_cmpl_valid) begin
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_cmpl t=%0t got %h want none", $time, act);
          end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
              n_err++;
              $display("FAIL cmpl t=%0t got %h want %h", $time, act, e);
            end
          end
        end else if (act !== '0) begin
          n_err++;
          $display("FAIL idle_payload t=%0t got %h want 0", $time, act);
        end
      end
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout got %0d cycles want stimulus done", cycles);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_cmpl got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
